// File: rtl/hilo_muldiv.sv
// hilo_muldiv: iterative unsigned multiply/divide unit with HI/LO result registers.
// A MUL or DIV request runs for n cycles, then a one-cycle DONE. After that, HI and LO
// hold the product (HI:LO) or the remainder (HI) and quotient (LO).
// Ports:
//   clk, reset     - clock; asynchronous active-high reset
//   start          - request strobe, accepted only in IDLE with a valid alu_decode
//   alu_decode     - 4'b0101 unsigned MUL, 4'b0110 unsigned DIV; other codes are ignored
//   rda, rdx       - operand A (multiplicand/dividend), operand B (multiplier/divisor)
//   busy, done     - operation in progress; one-cycle completion pulse
//   rd_sel         - read select (0: LO, 1: HI)
//   rd_data        - combinational read of the selected result register
//   Hi, Lo         - current result registers
module hilo_muldiv #(
  parameter int unsigned n = 32,
  parameter int unsigned m = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [m-1:0] alu_decode,
  input  logic [n-1:0] rda,
  input  logic [n-1:0] rdx,
  output logic         busy,
  output logic         done,
  input  logic         rd_sel,
  output logic [n-1:0] rd_data,
  output logic [n-1:0] Hi,
  output logic [n-1:0] Lo
);

  localparam int unsigned CW = (n > 1) ? $clog2(n) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(n - 1);
  localparam logic [m-1:0] OP_MUL = m'(5);
  localparam logic [m-1:0] OP_DIV = m'(6);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t          state;
  logic [n-1:0]    op_a;
  logic [n-1:0]    op_b;
  logic [2*n-1:0]  acc;
  logic [CW-1:0]   cnt;

  logic [n:0]      mul_sum;
  logic [2*n-1:0]  mul_next;
  logic [n:0]      div_part;
  logic            div_ge;
  logic [n-1:0]    div_rem;
  logic [2*n-1:0]  div_next;

  // One shift-add step: upper half accumulates the multiplicand when the current
  // multiplier bit (acc[0]) is set, then the whole accumulator shifts right.
  always_comb begin
    mul_sum  = {1'b0, acc[2*n-1:n]} + (acc[0] ? {1'b0, op_a} : '0);
    mul_next = {mul_sum, acc[n-1:1]};
  end

  // One restoring-divide step: upper half is the partial remainder, lower half
  // shifts dividend bits out at the top and quotient bits in at the bottom.
  // A zero divisor always subtracts nothing, giving an all-ones quotient and the dividend as remainder.
  always_comb begin
    div_part = {acc[2*n-1:n], acc[n-1]};
    div_ge   = (div_part >= {1'b0, op_b});
    div_rem  = div_ge ? n'(div_part - {1'b0, op_b}) : div_part[n-1:0];
    div_next = {div_rem, acc[n-2:0], div_ge};
  end

  assign rd_data = rd_sel ? Hi : Lo;

  // Control FSM and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      Hi    <= '0;
      Lo    <= '0;
      op_a  <= '0;
      op_b  <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && (alu_decode == OP_MUL)) begin
            op_a  <= rda;
            op_b  <= rdx;
            acc   <= {{n{1'b0}}, rdx};
            cnt   <= '0;
            busy  <= 1'b1;
            state <= MUL;
          end else if (start && (alu_decode == OP_DIV)) begin
            op_a  <= rda;
            op_b  <= rdx;
            acc   <= {{n{1'b0}}, rda};
            cnt   <= '0;
            busy  <= 1'b1;
            state <= DIV;
          end
        end
        MUL: begin
          acc <= mul_next;
          cnt <= cnt + CW'(1);
          if (cnt == LAST_ITER) begin
            Hi    <= mul_next[2*n-1:n];
            Lo    <= mul_next[n-1:0];
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DIV: begin
          acc <= div_next;
          cnt <= cnt + CW'(1);
          if (cnt == LAST_ITER) begin
            Hi    <= div_next[2*n-1:n];
            Lo    <= div_next[n-1:0];
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: directed cases, reset abort, ignored requests,
// back-to-back throughput and randomized MUL/DIV/invalid traffic against a reference model.
module tb_hilo_muldiv;

  localparam int unsigned N = 32;
  localparam int unsigned M = 4;
  localparam logic [3:0] OP_MUL = 4'b0101;
  localparam logic [3:0] OP_DIV = 4'b0110;
  localparam logic [3:0] OP_BAD = 4'b0001;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [M-1:0]  alu_decode;
  logic [N-1:0]  rda;
  logic [N-1:0]  rdx;
  logic          busy;
  logic          done;
  logic          rd_sel;
  logic [N-1:0]  rd_data;
  logic [N-1:0]  hi;
  logic [N-1:0]  lo;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  hilo_muldiv #(.n(N), .m(M)) dut (
    .clk(clk), .reset(reset), .start(start), .alu_decode(alu_decode),
    .rda(rda), .rdx(rdx), .busy(busy), .done(done), .rd_sel(rd_sel),
    .rd_data(rd_data), .Hi(hi), .Lo(lo)
  );

  // Reference result {HI, LO} from plain arithmetic; invalid ops leave the previous result.
  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] prev);
    if (op == OP_MUL) return 64'(a) * 64'(b);
    if (op == OP_DIV) begin
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      return {a % b, a / b};
    end
    return prev;
  endfunction

  // Issue one request in the next IDLE cycle and wait (bounded) for done.
  // lat = cycles from acceptance until done is seen (0 on timeout).
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cyc, output bit held);
    logic [31:0] h0, l0;
    h0 = hi; l0 = lo; held = 1'b1; busy_cyc = 0;
    @(negedge clk);
    start = 1'b1; alu_decode = op; rda = a; rdx = b;
    @(negedge clk);
    start = 1'b0; alu_decode = 4'($urandom); rda = $urandom; rdx = $urandom;
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) busy_cyc++;
      if (hi !== h0 || lo !== l0) held = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (done !== 1'b1) lat = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; alu_decode = '0; rda = '0; rdx = '0; rd_sel = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
    vectors++; if (hi !== 32'd0) begin miscompares++; $display("FAIL reset_hi got %h want 0", hi); end
    vectors++; if (lo !== 32'd0) begin miscompares++; $display("FAIL reset_lo got %h want 0", lo); end
    vectors++; if (rd_data !== 32'd0) begin miscompares++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_mul_directed();
    int lat, bc; bit held;
    run_op(OP_MUL, 32'd7, 32'd6, lat, bc, held);
    vectors++; if (lat != 33) begin miscompares++; $display("FAIL mul7x6_latency got %0d want 33", lat); end
    vectors++; if (bc != 32) begin miscompares++; $display("FAIL mul7x6_busy_cycles got %0d want 32", bc); end
    vectors++; if (held !== 1'b1) begin miscompares++; $display("FAIL mul7x6_hilo_hold got %b want 1", held); end
    vectors++; if (hi !== 32'h0) begin miscompares++; $display("FAIL mul7x6_hi got %h want 00000000", hi); end
    vectors++; if (lo !== 32'h2A) begin miscompares++; $display("FAIL mul7x6_lo got %h want 0000002a", lo); end
    rd_sel = 1'b0; #1;
    vectors++; if (rd_data !== 32'h2A) begin miscompares++; $display("FAIL mul7x6_rd_lo got %h want 0000002a", rd_data); end
    @(negedge clk);
    vectors++; if (done !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL done_one_cycle got done=%b busy=%b want 0 0", done, busy); end
    run_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc, held);
    vectors++; if (lat != 33) begin miscompares++; $display("FAIL mulmax_latency got %0d want 33", lat); end
    vectors++; if (hi !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL mulmax_hi got %h want fffffffe", hi); end
    vectors++; if (lo !== 32'h1) begin miscompares++; $display("FAIL mulmax_lo got %h want 00000001", lo); end
    rd_sel = 1'b1; #1;
    vectors++; if (rd_data !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL mulmax_rd_hi got %h want fffffffe", rd_data); end
    rd_sel = 1'b0;
  endtask

  task automatic test_div_directed();
    int lat, bc; bit held;
    run_op(OP_DIV, 32'd100, 32'd7, lat, bc, held);
    vectors++; if (lat != 33) begin miscompares++; $display("FAIL div100_7_latency got %0d want 33", lat); end
    vectors++; if (held !== 1'b1) begin miscompares++; $display("FAIL div100_7_hilo_hold got %b want 1", held); end
    vectors++; if (lo !== 32'd14) begin miscompares++; $display("FAIL div100_7_lo got %0d want 14", lo); end
    vectors++; if (hi !== 32'd2) begin miscompares++; $display("FAIL div100_7_hi got %0d want 2", hi); end
    run_op(OP_DIV, 32'd5, 32'd0, lat, bc, held);
    vectors++; if (lat != 33) begin miscompares++; $display("FAIL div5_0_latency got %0d want 33", lat); end
    vectors++; if (lo !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL div5_0_lo got %h want ffffffff", lo); end
    vectors++; if (hi !== 32'd5) begin miscompares++; $display("FAIL div5_0_hi got %h want 00000005", hi); end
  endtask

  task automatic test_ignore_start();
    int cyc, lat, bc; bit held;
    @(negedge clk);
    start = 1'b1; alu_decode = OP_MUL; rda = 32'd3; rdx = 32'd4;
    @(negedge clk);
    start = 1'b0; cyc = 1;
    repeat (3) begin @(negedge clk); cyc++; end
    start = 1'b1; alu_decode = OP_DIV; rda = 32'd9; rdx = 32'd3;
    @(negedge clk); cyc++;
    start = 1'b0;
    while (done !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
    vectors++; if (cyc != 33) begin miscompares++; $display("FAIL ignore_start_latency got %0d want 33", cyc); end
    vectors++; if (lo !== 32'd12) begin miscompares++; $display("FAIL ignore_start_lo got %0d want 12", lo); end
    vectors++; if (hi !== 32'd0) begin miscompares++; $display("FAIL ignore_start_hi got %0d want 0", hi); end
    run_op(OP_DIV, 32'd9, 32'd3, lat, bc, held);
    vectors++; if (lat != 33) begin miscompares++; $display("FAIL div_after_done_latency got %0d want 33", lat); end
    vectors++; if (lo !== 32'd3) begin miscompares++; $display("FAIL div_after_done_lo got %0d want 3", lo); end
    vectors++; if (hi !== 32'd0) begin miscompares++; $display("FAIL div_after_done_hi got %0d want 0", hi); end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, bc; bit held;
    longint t1, t2;
    logic [31:0] a1, b1, a2, b2;
    logic [63:0] exp;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = 32'($urandom_range(1, 1000));
    run_op(OP_MUL, a1, b1, lat1, bc, held);
    t1 = longint'($time);
    exp = model(OP_MUL, a1, b1, 64'd0);
    vectors++; if ({hi, lo} !== exp) begin miscompares++; $display("FAIL b2b_mul got %h want %h", {hi, lo}, exp); end
    run_op(OP_DIV, a2, b2, lat2, bc, held);
    t2 = longint'($time);
    exp = model(OP_DIV, a2, b2, 64'd0);
    vectors++; if ({hi, lo} !== exp) begin miscompares++; $display("FAIL b2b_div got %h want %h", {hi, lo}, exp); end
    vectors++; if (lat2 != 33 || (t2 - t1) != 64'd340) begin miscompares++; $display("FAIL b2b_spacing got lat=%0d dt=%0d want lat=33 dt=340", lat2, t2 - t1); end
  endtask

  task automatic test_reset_abort();
    int cyc, lat, bc; bit held; bit saw_done;
    @(negedge clk);
    start = 1'b1; alu_decode = OP_MUL; rda = 32'd2; rdx = 32'd2;
    @(negedge clk);
    start = 1'b0; cyc = 1;
    repeat (9) begin @(negedge clk); cyc++; end
    #1 reset = 1'b1;
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy got %b want 0", busy); end
    vectors++; if (hi !== 32'd0 || lo !== 32'd0) begin miscompares++; $display("FAIL abort_hilo got %h_%h want 0_0", hi, lo); end
    #1 reset = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin @(negedge clk); if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1; end
    vectors++; if (saw_done !== 1'b0) begin miscompares++; $display("FAIL abort_no_done got activity=%b want 0", saw_done); end
    run_op(OP_MUL, 32'd2, 32'd2, lat, bc, held);
    vectors++; if (lat != 33 || lo !== 32'd4 || hi !== 32'd0) begin miscompares++; $display("FAIL post_reset_mul got lat=%0d hi=%h lo=%h want 33 0 4", lat, hi, lo); end
  endtask

  task automatic test_invalid();
    int lat, bc; bit held; bit active;
    logic [63:0] exp;
    run_op(OP_MUL, 32'h1234_5678, 32'h0000_0100, lat, bc, held);
    exp = model(OP_MUL, 32'h1234_5678, 32'h0000_0100, 64'd0);
    @(negedge clk);
    start = 1'b1; alu_decode = OP_BAD; rda = 32'd11; rdx = 32'd13;
    @(negedge clk);
    start = 1'b0;
    active = 1'b0;
    repeat (40) begin if (busy !== 1'b0 || done !== 1'b0) active = 1'b1; @(negedge clk); end
    vectors++; if (active !== 1'b0) begin miscompares++; $display("FAIL invalid_busy got activity=%b want 0", active); end
    vectors++; if ({hi, lo} !== exp) begin miscompares++; $display("FAIL invalid_hilo got %h want %h", {hi, lo}, exp); end
  endtask

  task automatic test_random();
    int lat, bc; bit held; bit active;
    logic [3:0] op;
    logic [31:0] a, b;
    logic [63:0] prev, exp;
    prev = {hi, lo};
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0, 1:    op = OP_MUL;
        2, 3:    op = OP_DIV;
        default: op = 4'($urandom_range(0, 15));
      endcase
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 255));
        default: b = $urandom;
      endcase
      exp = model(op, a, b, prev);
      if (op == OP_MUL || op == OP_DIV) begin
        run_op(op, a, b, lat, bc, held);
        vectors++; if (lat != 33 || bc != 32 || held !== 1'b1) begin miscompares++; $display("FAIL rand%0d_timing got lat=%0d busy=%0d held=%b want 33 32 1", i, lat, bc, held); end
        rd_sel = 1'($urandom); #1;
        vectors++; if ({hi, lo} !== exp || rd_data !== (rd_sel ? exp[63:32] : exp[31:0])) begin miscompares++; $display("FAIL rand%0d_result op=%h a=%h b=%h got %h rd=%h want %h", i, op, a, b, {hi, lo}, rd_data, exp); end
      end else begin
        @(negedge clk);
        start = 1'b1; alu_decode = op; rda = a; rdx = b;
        @(negedge clk);
        start = 1'b0;
        active = 1'b0;
        repeat (3) begin if (busy !== 1'b0 || done !== 1'b0) active = 1'b1; @(negedge clk); end
        vectors++; if (active !== 1'b0 || {hi, lo} !== exp) begin miscompares++; $display("FAIL rand%0d_invalid op=%h got active=%b hilo=%h want 0 %h", i, op, active, {hi, lo}, exp); end
      end
      prev = exp;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_mul_directed();
    test_div_directed();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_invalid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
